// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe
//   Pipelined MIPS main decoder that sits in front of the ID/EX boundary.
//   It takes one instruction per cycle, decodes it into an 18-bit control
//   bundle and holds the bundle in a one-entry output register. A HI/LO
//   scoreboard counter interlocks HI/LO instructions behind an in-flight
//   multiply or divide.
//
// Parameters
//   MUL_LAT      cycles HI/LO stay busy after an accepted MULT/MULTU (1..255)
//   DIV_LAT      cycles HI/LO stay busy after an accepted DIV/DIVU  (1..255)
//   ILLEGAL_TRAP 1: undecodable instructions raise out_ri; 0: out_ri stays 0
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   in_valid/in_ready input handshake; in_instr, in_pc carried with it
//   flush             drops the held entry and blocks acceptance this cycle
//   out_valid/out_ready output handshake for the held entry
//   out_ctrl          {aluop[3:0], alusrc[1:0], hilowrite[1:0], regwrite,
//                      regdst, memwrite, memtoreg, branch, bal, jump, jal,
//                      jr, jalr}
//   out_instr, out_pc registered instruction word and PC
//   out_ri            reserved-instruction flag for the held entry
//   hilo_busy         HI/LO scoreboard counter is nonzero
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A source holding valid keeps its payload stable until the
// transfer; ready never depends on anything the source may change after
// asserting valid except the instruction class it presents.
module decode_stage_pipe #(
    parameter int unsigned MUL_LAT      = 2,
    parameter int unsigned DIV_LAT      = 32,
    parameter bit          ILLEGAL_TRAP = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [17:0] out_ctrl,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_ri,
    output logic        hilo_busy
);

    // ALU operation codes shared with the execute stage.
    localparam logic [3:0] ALU_MEM   = 4'b0000;
    localparam logic [3:0] ALU_RTYPE = 4'b0010;
    localparam logic [3:0] ALU_ADDI  = 4'b0100;
    localparam logic [3:0] ALU_ADDIU = 4'b0101;
    localparam logic [3:0] ALU_SLTI  = 4'b0110;
    localparam logic [3:0] ALU_SLTIU = 4'b0111;
    localparam logic [3:0] ALU_ANDI  = 4'b1000;
    localparam logic [3:0] ALU_ORI   = 4'b1001;
    localparam logic [3:0] ALU_XORI  = 4'b1010;
    localparam logic [3:0] ALU_LUI   = 4'b1011;

    localparam logic [7:0] MUL_CNT = 8'(MUL_LAT);
    localparam logic [7:0] DIV_CNT = 8'(DIV_LAT);

    logic [5:0] op;
    logic [4:0] rt;
    logic [5:0] funct;

    assign op    = in_instr[31:26];
    assign rt    = in_instr[20:16];
    assign funct = in_instr[5:0];

    // Decoded control fields
    logic [3:0] aluop;
    logic [1:0] alusrc;
    logic [1:0] hilowrite;
    logic       regwrite, regdst, memwrite, memtoreg;
    logic       branch, bal, jump, jal, jr, jalr;
    logic       unknown;
    logic [17:0] dec_ctrl;
    logic        dec_ri;

    always_comb begin
        aluop     = 4'b0000;
        alusrc    = 2'b00;
        hilowrite = 2'b00;
        regwrite  = 1'b0;
        regdst    = 1'b0;
        memwrite  = 1'b0;
        memtoreg  = 1'b0;
        branch    = 1'b0;
        bal       = 1'b0;
        jump      = 1'b0;
        jal       = 1'b0;
        jr        = 1'b0;
        jalr      = 1'b0;
        unknown   = 1'b0;
        case (op)
            6'h00: begin
                case (funct)
                    6'h11: hilowrite = 2'b10;                      // MTHI
                    6'h13: hilowrite = 2'b01;                      // MTLO
                    6'h18, 6'h19, 6'h1a, 6'h1b: hilowrite = 2'b11; // MULT/DIV
                    6'h08: jr = 1'b1;
                    6'h09: begin
                        regwrite = 1'b1;
                        regdst   = 1'b1;
                        jalr     = 1'b1;
                    end
                    // MFHI/MFLO decode exactly like an ordinary R-type
                    default: begin
                        aluop    = ALU_RTYPE;
                        regwrite = 1'b1;
                        regdst   = 1'b1;
                    end
                endcase
            end
            6'h01: begin
                case (rt)
                    5'h00, 5'h01: branch = 1'b1;   // BLTZ/BGEZ
                    5'h10, 5'h11: begin            // BLTZAL/BGEZAL
                        regwrite = 1'b1;
                        branch   = 1'b1;
                        bal      = 1'b1;
                    end
                    default: unknown = 1'b1;
                endcase
            end
            6'h02: jump = 1'b1;
            6'h03: begin
                regwrite = 1'b1;
                jal      = 1'b1;
            end
            6'h04, 6'h05, 6'h06, 6'h07: branch = 1'b1;
            6'h08: begin aluop = ALU_ADDI;  alusrc = 2'b01; regwrite = 1'b1; end
            6'h09: begin aluop = ALU_ADDIU; alusrc = 2'b01; regwrite = 1'b1; end
            6'h0a: begin aluop = ALU_SLTI;  alusrc = 2'b01; regwrite = 1'b1; end
            6'h0b: begin aluop = ALU_SLTIU; alusrc = 2'b01; regwrite = 1'b1; end
            // Logical immediates and LUI zero-extend, hence alusrc=10
            6'h0c: begin aluop = ALU_ANDI;  alusrc = 2'b10; regwrite = 1'b1; end
            6'h0d: begin aluop = ALU_ORI;   alusrc = 2'b10; regwrite = 1'b1; end
            6'h0e: begin aluop = ALU_XORI;  alusrc = 2'b10; regwrite = 1'b1; end
            6'h0f: begin aluop = ALU_LUI;   alusrc = 2'b10; regwrite = 1'b1; end
            6'h23: begin
                aluop    = ALU_MEM;
                alusrc   = 2'b01;
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            6'h2b: begin
                aluop    = ALU_MEM;
                alusrc   = 2'b01;
                memwrite = 1'b1;
            end
            default: unknown = 1'b1;
        endcase
    end

    assign dec_ctrl = {aluop, alusrc, hilowrite, regwrite, regdst, memwrite,
                       memtoreg, branch, bal, jump, jal, jr, jalr};
    assign dec_ri   = unknown & ILLEGAL_TRAP;

    // HI/LO scoreboard
    logic       is_hilo, is_mul, is_div;
    logic [7:0] cnt;
    logic       hazard, accept;

    assign is_mul  = (op == 6'h00) && (funct == 6'h18 || funct == 6'h19);
    assign is_div  = (op == 6'h00) && (funct == 6'h1a || funct == 6'h1b);
    assign is_hilo = (op == 6'h00) &&
                     (funct == 6'h10 || funct == 6'h11 || funct == 6'h12 ||
                      funct == 6'h13 || is_mul || is_div);

    assign hazard    = in_valid & is_hilo & (cnt != 8'd0);
    assign in_ready  = ~rst & ~flush & ~hazard & (~out_valid | out_ready);
    assign accept    = in_valid & in_ready;
    assign hilo_busy = (cnt != 8'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_ctrl  <= '0;
            out_instr <= '0;
            out_pc    <= '0;
            out_ri    <= 1'b0;
            cnt       <= 8'd0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_ctrl  <= dec_ctrl;
                out_instr <= in_instr;
                out_pc    <= in_pc;
                out_ri    <= dec_ri;
            end else if (flush | out_ready) begin
                // Flush drops the entry but leaves the data registers as-is
                out_valid <= 1'b0;
            end

            // A load only happens with cnt==0 since the hazard blocks it.
            // Flush does not touch cnt: the issued mul/div keeps running.
            if (accept && is_mul) begin
                cnt <= MUL_CNT;
            end else if (accept && is_div) begin
                cnt <= DIV_CNT;
            end else if (cnt != 8'd0) begin
                cnt <= cnt - 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage_pipe.sv
module tb_decode_stage_pipe;

    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 4;

    localparam logic [3:0] ALU_MEM   = 4'b0000;
    localparam logic [3:0] ALU_RTYPE = 4'b0010;
    localparam logic [3:0] ALU_ADDI  = 4'b0100;
    localparam logic [3:0] ALU_ADDIU = 4'b0101;
    localparam logic [3:0] ALU_SLTI  = 4'b0110;
    localparam logic [3:0] ALU_SLTIU = 4'b0111;
    localparam logic [3:0] ALU_ANDI  = 4'b1000;
    localparam logic [3:0] ALU_ORI   = 4'b1001;
    localparam logic [3:0] ALU_XORI  = 4'b1010;
    localparam logic [3:0] ALU_LUI   = 4'b1011;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_ready;

    logic        in_ready, out_valid, out_ri, hilo_busy;
    logic [17:0] out_ctrl;
    logic [31:0] out_instr, out_pc;

    logic        b_in_ready, b_out_valid, b_out_ri, b_hilo_busy;
    logic [17:0] b_out_ctrl;
    logic [31:0] b_out_instr, b_out_pc;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    decode_stage_pipe #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .ILLEGAL_TRAP(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_instr(out_instr), .out_pc(out_pc), .out_ri(out_ri),
        .hilo_busy(hilo_busy)
    );

    // Same pipeline with trapping disabled; it sees identical stimulus
    decode_stage_pipe #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .ILLEGAL_TRAP(1'b0)) dut_notrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_ctrl(b_out_ctrl),
        .out_instr(b_out_instr), .out_pc(b_out_pc), .out_ri(b_out_ri),
        .hilo_busy(b_hilo_busy)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    logic [82:0] exp_q[$];   // {ri, ctrl[17:0], instr[31:0], pc[31:0]}

    // Reference model state: whether an entry is held, and the edge index
    // up to which HI/LO is busy (busy after edge e while e < busy_until).
    bit m_valid    = 1'b0;
    int edge_cnt   = 0;
    int busy_until = 0;
    logic [31:0] pc_next = 32'h0040_0000;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference decode ----------------
    function automatic bit ref_is_hilo(input logic [31:0] w);
        return (w[31:26] == 6'h00) &&
               (w[5:0] inside {6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b});
    endfunction

    // Returns {ri, ctrl[17:0]}
    function automatic logic [18:0] ref_decode(input logic [31:0] w, input bit trap);
        logic [5:0] op;
        logic [4:0] rt;
        logic [5:0] fn;
        logic [3:0] a;
        logic [1:0] s, h;
        bit rw, rd, mw, mr, br, bl, j, jl, r, rl, ri;
        op = w[31:26];
        rt = w[20:16];
        fn = w[5:0];
        a = 4'd0; s = 2'd0; h = 2'd0;
        {rw, rd, mw, mr, br, bl, j, jl, r, rl, ri} = '0;
        if (op == 6'h00) begin
            if (fn == 6'h11) h = 2'b10;
            else if (fn == 6'h13) h = 2'b01;
            else if (fn inside {6'h18, 6'h19, 6'h1a, 6'h1b}) h = 2'b11;
            else if (fn == 6'h08) r = 1;
            else if (fn == 6'h09) begin rw = 1; rd = 1; rl = 1; end
            else begin a = ALU_RTYPE; rw = 1; rd = 1; end
        end else if (op == 6'h01) begin
            if (rt == 5'h00 || rt == 5'h01) br = 1;
            else if (rt == 5'h10 || rt == 5'h11) begin rw = 1; br = 1; bl = 1; end
            else ri = 1;
        end else if (op == 6'h02) j = 1;
        else if (op == 6'h03) begin rw = 1; jl = 1; end
        else if (op inside {6'h04, 6'h05, 6'h06, 6'h07}) br = 1;
        else if (op == 6'h08) begin a = ALU_ADDI;  s = 2'b01; rw = 1; end
        else if (op == 6'h09) begin a = ALU_ADDIU; s = 2'b01; rw = 1; end
        else if (op == 6'h0a) begin a = ALU_SLTI;  s = 2'b01; rw = 1; end
        else if (op == 6'h0b) begin a = ALU_SLTIU; s = 2'b01; rw = 1; end
        else if (op == 6'h0c) begin a = ALU_ANDI;  s = 2'b10; rw = 1; end
        else if (op == 6'h0d) begin a = ALU_ORI;   s = 2'b10; rw = 1; end
        else if (op == 6'h0e) begin a = ALU_XORI;  s = 2'b10; rw = 1; end
        else if (op == 6'h0f) begin a = ALU_LUI;   s = 2'b10; rw = 1; end
        else if (op == 6'h23) begin a = ALU_MEM; s = 2'b01; rw = 1; mr = 1; end
        else if (op == 6'h2b) begin a = ALU_MEM; s = 2'b01; mw = 1; end
        else ri = 1;
        return {ri & trap, a, s, h, rw, rd, mw, mr, br, bl, j, jl, r, rl};
    endfunction

    // ---------------- instruction builders ----------------
    function automatic logic [31:0] mk_r(input logic [5:0] fn);
        logic [31:0] w;
        w = $urandom;
        w[31:26] = 6'h00;
        w[5:0]   = fn;
        return w;
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op);
        logic [31:0] w;
        w = $urandom;
        w[31:26] = op;
        return w;
    endfunction

    function automatic logic [31:0] mk_regimm(input logic [4:0] rt);
        logic [31:0] w;
        w = mk_i(6'h01);
        w[20:16] = rt;
        return w;
    endfunction

    logic [5:0] op_tab [0:17] = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09,
                                  6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h23, 6'h2b,
                                  6'h3f, 6'h01};
    logic [5:0] hl_tab [0:7]  = '{6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b};

    function automatic logic [31:0] gen_instr();
        case ($urandom_range(0, 5))
            0, 1:    return mk_r(hl_tab[$urandom_range(0, 7)]);
            2:       return mk_r(6'($urandom));
            3:       return mk_i(op_tab[$urandom_range(0, 17)]);
            4:       return mk_regimm(5'($urandom));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- driver ----------------
    // One clock cycle of stimulus. The model predicts in_ready, hilo_busy and
    // out_valid; an accepted instruction pushes its expected entry.
    task automatic step(input bit v, input logic [31:0] instr, input bit ordy,
                        input bit fl, input bit r, output bit acc, output bit dut_rdy);
        bit busy, exp_rdy;
        @(negedge clk);
        rst = r; in_valid = v; in_instr = instr; in_pc = pc_next;
        out_ready = ordy; flush = fl;
        #1;
        busy    = (edge_cnt < busy_until);
        exp_rdy = !r && !fl && !(v && ref_is_hilo(instr) && busy) && (!m_valid || ordy);
        dut_rdy = in_ready;
        chk("in_ready", in_ready, exp_rdy);
        chk("hilo_busy", hilo_busy, busy);
        chk("out_valid", out_valid, m_valid);
        acc = v && exp_rdy;
        if (acc) exp_q.push_back({ref_decode(instr, 1'b1), instr, pc_next});
        @(posedge clk);
        edge_cnt++;
        if (r) begin
            m_valid    = 1'b0;
            busy_until = 0;
            exp_q.delete();
        end else begin
            if (acc) m_valid = 1'b1;
            else if (fl || ordy) m_valid = 1'b0;
            if (acc && (instr[31:26] == 6'h00) && (instr[5:0] inside {6'h18, 6'h19}))
                busy_until = edge_cnt + MUL_LAT;
            if (acc && (instr[31:26] == 6'h00) && (instr[5:0] inside {6'h1a, 6'h1b}))
                busy_until = edge_cnt + DIV_LAT;
        end
        if (acc) pc_next = pc_next + 32'd4;
    endtask

    // Present one instruction until the model accepts it; counts the cycles
    // in which the DUT held in_ready low. rnd adds backpressure and flushes.
    task automatic present(input logic [31:0] instr, input bit rnd, output int lows);
        bit acc, dr, ordy, fl;
        int n;
        lows = 0;
        acc  = 1'b0;
        n    = 0;
        while (!acc && n < 200) begin
            ordy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            fl   = rnd ? ($urandom_range(0, 15) == 0) : 1'b0;
            step(1'b1, instr, ordy, fl, 1'b0, acc, dr);
            if (!dr) lows++;
            n++;
        end
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        bit acc, dr;
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, acc, dr);
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [82:0] front;
        forever begin
            @(negedge clk);
            #2;
            if (rst !== 1'b1 && out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", out_instr, 0);
                end else begin
                    front = exp_q[0];
                    chk("out_ctrl", out_ctrl, front[81:64]);
                    chk("out_instr", out_instr, front[63:32]);
                    chk("out_pc", out_pc, front[31:0]);
                    chk("out_ri", out_ri, front[82]);
                    chk("notrap_out", {b_out_valid, b_out_ri, b_out_ctrl}, {2'b10, front[81:64]});
                    if (out_ready || flush) void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        bit acc, dr;
        int lows;

        rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        flush = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, acc, dr);
        step(1'b1, mk_i(6'h0d), 1'b1, 1'b0, 1'b1, acc, dr);   // in_ready low in reset
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("rst_out_ctrl", out_ctrl, 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_ri", out_ri, 0);
        chk("rst_hilo_busy", hilo_busy, 0);

        // Full-rate stream of ordinary instructions
        present(mk_i(6'h0d), 1'b0, lows);
        present(mk_i(6'h09), 1'b0, lows);
        present(mk_i(6'h23), 1'b0, lows);
        present(mk_i(6'h2b), 1'b0, lows);
        present(mk_i(6'h04), 1'b0, lows);
        present(mk_i(6'h03), 1'b0, lows);
        chk("stream_no_stall", lows, 0);
        idle(2);

        // DIV then dependent MFLO: blocked DIV_LAT cycles
        present(mk_r(6'h1a), 1'b0, lows);
        present(mk_r(6'h12), 1'b0, lows);
        chk("mflo_stall_cycles", lows, DIV_LAT);
        // DIV then independent ADDU: no stall
        present(mk_r(6'h1b), 1'b0, lows);
        present(mk_r(6'h21), 1'b0, lows);
        chk("addu_no_stall", lows, 0);
        idle(DIV_LAT + 1);

        // Backpressure while holding SW
        present(mk_i(6'h2b), 1'b0, lows);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h0000_0021, 1'b0, 1'b0, 1'b0, acc, dr);
            chk("bp_blocked", dr, 0);
        end
        step(1'b1, 32'h0000_0021, 1'b1, 1'b0, 1'b0, acc, dr);
        chk("bp_release_accept", dr, 1);
        idle(1);

        // Flush with a held entry and a presented input; MULT keeps counting
        present(mk_r(6'h18), 1'b0, lows);
        present(mk_i(6'h0d), 1'b0, lows);
        step(1'b1, mk_r(6'h21), 1'b0, 1'b1, 1'b0, acc, dr);
        chk("flush_blocks_input", dr, 0);
        idle(1);
        chk("flush_cleared_valid", out_valid, 0);
        present(mk_r(6'h21), 1'b0, lows);
        idle(MUL_LAT);

        // Reserved instructions
        present({6'h3f, 26'h155_5555}, 1'b0, lows);
        present(mk_regimm(5'h07), 1'b0, lows);
        present(mk_regimm(5'h11), 1'b0, lows);
        idle(1);

        // Reset in the middle of a divide
        present(mk_r(6'h1a), 1'b0, lows);
        idle(1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, acc, dr);
        present(mk_r(6'h10), 1'b0, lows);
        chk("mfhi_after_reset", lows, 0);
        idle(1);

        // Randomized traffic with gaps, backpressure and occasional flushes
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                step(1'b0, 32'h0, ($urandom_range(0, 1) == 1), 1'b0, 1'b0, acc, dr);
            end
            present(gen_instr(), 1'b1, lows);
        end
        idle(DIV_LAT + 3);
        chk("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_stage_pipe.md
# decode_stage_pipe

Pipelined, stall-aware successor to the single-cycle main decoder. It accepts one 32-bit MIPS instruction per cycle over a valid/ready handshake and decodes it into the 18-bit control bundle. The bundle is held in a one-entry output register in front of the ID/EX boundary. A HI/LO scoreboard with parametrised multiply and divide latencies interlocks dependent HI/LO instructions, and the block supports flush and reserved-instruction flagging.

## Interface
- MUL_LAT, 2: cycles HI/LO stay busy after an accepted MULT/MULTU; range 1..255.
- DIV_LAT, 32: cycles HI/LO stay busy after an accepted DIV/DIVU; range 1..255.
- ILLEGAL_TRAP, 1: 1 raises out_ri for undecodable instructions; 0 keeps out_ri at 0.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_instr/in_pc are valid.
- in_ready  out  1  block accepts this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  32  instruction PC.
- flush  in  1  kill the held entry, block acceptance this cycle.
- out_valid  out  1  output entry is valid.
- out_ready  in  1  downstream consumes the entry.
- out_ctrl  out  18  {aluop[3:0], alusrc[1:0], hilowrite[1:0], regwrite, regdst, memwrite, memtoreg, branch, bal, jump, jal, jr, jalr}.
- out_instr  out  32  registered instruction.
- out_pc  out  32  registered PC.
- out_ri  out  1  reserved instruction flag.
- hilo_busy  out  1  scoreboard counter is nonzero.

## Operation
- Decode is combinational from in_instr, on op=[31:26], rt=[20:16] and funct=[5:0]. Aluop codes come from defines.vh. Each class sets the following fields; all other fields are 0.
  - SPECIAL MFHI/MFLO: R-type aluop, regwrite, regdst.
  - MTHI: hilowrite=10. MTLO: hilowrite=01.
  - MULT/MULTU/DIV/DIVU: hilowrite=11.
  - JR: jr. JALR: regwrite, regdst, jalr.
  - Any other funct: R-type aluop, regwrite, regdst.
  - ANDI/XORI/LUI/ORI: own aluop, alusrc=10, regwrite.
  - ADDI/ADDIU/SLTI/SLTIU: own aluop, alusrc=01, regwrite.
  - BEQ/BNE/BLEZ/BGTZ and REGIMM BLTZ/BGEZ: branch.
  - BLTZAL/BGEZAL: regwrite, branch, bal.
  - J: jump. JAL: regwrite, jal.
  - LW: MEM aluop, alusrc=01, regwrite, memtoreg. SW: MEM aluop, alusrc=01, memwrite.
  - Unknown op, or REGIMM with unknown rt: all fields 0, with out_ri=ILLEGAL_TRAP.
- A HI/LO-class instruction is MFHI, MFLO, MTHI, MTLO, MULT, MULTU, DIV or DIVU.
- hazard = in_valid & HI/LO-class & (cnt != 0).
- in_ready = !flush & !hazard & (!out_valid | out_ready).
- Accept = in_valid & in_ready. On accept, out_ctrl/out_instr/out_pc/out_ri load and out_valid=1.
- If out_valid & out_ready & !accept, out_valid clears next cycle.
- A flush clears out_valid next cycle. Data registers keep their values. Flush does not alter cnt, because the issued mul/div keeps running.
- Scoreboard cnt is 8 bits:
  - On an accepted MULT/MULTU, cnt loads MUL_LAT.
  - On an accepted DIV/DIVU, cnt loads DIV_LAT.
  - Otherwise cnt decrements when nonzero and saturates at 0.
  - A load cannot coincide with cnt != 0, because the hazard blocks it.
- hilo_busy = (cnt != 0). Non-HI/LO instructions accept regardless of cnt.

## Timing
- Reset (rst=1 at an edge) sets out_valid=0, out_ctrl=0, out_instr=0, out_pc=0, out_ri=0 and cnt=0. in_ready is 0 while rst=1.
- Reset mid-operation discards the held entry and clears the scoreboard immediately.
- Latency is 1 cycle: accept at edge t gives out_valid=1 with the decoded bundle after edge t.
- Full throughput is 1 instruction/cycle when out_ready=1 and there is no hazard.
- Backpressure: when out_valid=1 and out_ready=0, in_ready=0 and the outputs are held stable.
- Accept of a MUL/DIV at edge t gives cnt=LAT after t, with hilo_busy high for LAT cycles. A dependent HI/LO instruction accepts at edge t+LAT+1 at the earliest.
- Flush and in_valid in the same cycle: the input is not accepted, and the source must re-present it. Flush together with out_ready=1: the entry is dropped, which is the same as a consume.
- The input must hold in_valid/in_instr stable until accepted (no retraction).

## Test plan
- Reset then stream: ORI, ADDIU, LW, SW, BEQ, JAL, each at 1/cycle with out_ready=1 -> each bundle appears 1 cycle later. LW gives alusrc=01, regwrite=1, memtoreg=1. JAL gives regwrite=1, jal=1.
- Issue DIV with DIV_LAT=4, then MFLO next cycle -> hilo_busy high for 4 cycles, MFLO in_ready=0 for 4 cycles, accepted on the 5th. An ADDU behind the DIV instead of MFLO accepts immediately.
- out_ready=0 for 3 cycles while holding SW -> out_* stable, in_ready=0. When out_ready rises, SW is consumed and the next instruction is accepted in the same cycle.
- Flush asserted with out_valid=1 and in_valid=1 -> out_valid=0 next cycle and the input is not accepted. A MULT issued earlier keeps hilo_busy counting down.
- op=6'b111111, and REGIMM with rt=5'b00111, each with ILLEGAL_TRAP=1 -> out_ctrl=0 and out_ri=1. With ILLEGAL_TRAP=0 the same inputs give out_ri=0.
- Assert rst mid-DIV (cnt=10) -> next cycle cnt=0, hilo_busy=0, out_valid=0, and MFHI accepted right after rst drops.
